one_bit_seq: RTL and testbench

Sequencing and state-holding stage for the one-bit CPU. It owns the architectural REG and PC flip-flops and a 2-entry instruction store. Each committed cycle it presents {reg, pc, code} to the combinational ALU and latches the ALU's next-reg and next-pc. It adds run/step/stop control, halt detection, a cycle counter and a single-entry valid/ready trace port for the bench or a debug host.

---
 rtl/one_bit_seq_pkg.sv | 10 +
 rtl/one_bit_seq_if.sv | 24 ++
 rtl/one_bit_seq_trace_slot.sv | 35 +++
 rtl/one_bit_seq.sv | 95 +++++++++
 tb/tb_one_bit_seq.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/one_bit_seq_pkg.sv
// one_bit_pkg: shared types and constants for the one-bit CPU sequencer
package one_bit_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  localparam logic [1:0] HALT_NONE  = 2'd0;
  localparam logic [1:0] HALT_SELF  = 2'd1;
  localparam logic [1:0] HALT_LIMIT = 2'd2;
  localparam logic [1:0] HALT_STOP  = 2'd3;
  localparam logic CMD_XOR = 1'b0;
  localparam logic CMD_JMP = 1'b1;
endpackage

// File: rtl/one_bit_seq_if.sv
// one_bit_seq_if: ALU hookup and trace port of the one-bit CPU sequencer
//   alu_code/alu_reg/alu_pc   : sequencer -> ALU operands
//   alu_reg_nxt/alu_pc_nxt    : ALU -> sequencer results
//   trace_valid/pc/code/reg   : committed-instruction record, ready from consumer
interface one_bit_seq_if;
  logic [1:0] alu_code;
  logic       alu_reg;
  logic       alu_pc;
  logic       alu_reg_nxt;
  logic       alu_pc_nxt;
  logic       trace_valid;
  logic       trace_ready;
  logic       trace_pc;
  logic [1:0] trace_code;
  logic       trace_reg;
  modport master (
    output alu_code, alu_reg, alu_pc, trace_valid, trace_pc, trace_code, trace_reg,
    input  alu_reg_nxt, alu_pc_nxt, trace_ready
  );
  modport slave (
    input  alu_code, alu_reg, alu_pc, trace_valid, trace_pc, trace_code, trace_reg,
    output alu_reg_nxt, alu_pc_nxt, trace_ready
  );
endinterface

// File: rtl/one_bit_seq_trace_slot.sv
// one_bit_trace_slot: single-entry valid/ready register for committed instructions
//   clr   : drop any held entry (run restart)
//   load  : capture new_* and raise valid; wins over a same-cycle drain
//   ready : consumer accepts the held entry
module one_bit_trace_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic       ready,
  input  logic       new_pc,
  input  logic [1:0] new_code,
  input  logic       new_reg,
  output logic       trace_valid,
  output logic       trace_pc,
  output logic [1:0] trace_code,
  output logic       trace_reg
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      trace_valid <= 1'b0;
      trace_pc    <= 1'b0;
      trace_code  <= 2'b00;
      trace_reg   <= 1'b0;
    end else if (clr) begin
      trace_valid <= 1'b0;
    end else if (load) begin
      trace_valid <= 1'b1;
      trace_pc    <= new_pc;
      trace_code  <= new_code;
      trace_reg   <= new_reg;
    end else if (ready) begin
      trace_valid <= 1'b0;
    end
endmodule

// File: rtl/one_bit_seq.sv
// one_bit_seq: REG/PC state, 2-entry instruction store and run control for the one-bit CPU
//   prog_we/addr/data : store write (ignored while running)
//   start/step_mode/step/stop : run control
//   busy/halted/halt_cause/cycle_cnt : status
//   bus (master)      : external ALU operands/results and trace port
module one_bit_seq
  import one_bit_pkg::*;
#(
  parameter int CYC_W   = 8,
  parameter int MAX_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prog_we,
  input  logic             prog_addr,
  input  logic [1:0]       prog_data,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic             stop,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CYC_W-1:0] cycle_cnt,
  one_bit_seq_if.master    bus
);
  state_t     state_q, state_d;
  logic [1:0] cause_d;
  logic       reg_q, pc_q;
  logic [1:0] mem [2];
  logic [1:0] code;
  logic       enter_run, commit, self_jmp, at_limit;
  assign code      = mem[pc_q];
  assign busy      = state_q == RUN;
  assign halted    = state_q == HALT;
  assign enter_run = start && !busy;
  // a held trace entry blocks the next commit until the consumer takes it
  assign commit    = busy && (!step_mode || step) && (!bus.trace_valid || bus.trace_ready) && !stop;
  assign self_jmp  = code[1] == CMD_JMP && code[0] == pc_q;
  assign at_limit  = cycle_cnt + CYC_W'(1) == CYC_W'(MAX_CYC);
  assign bus.alu_code = code;
  assign bus.alu_reg  = reg_q;
  assign bus.alu_pc   = pc_q;
  always_comb begin
    state_d = state_q;
    cause_d = halt_cause;
    if (enter_run) begin
      state_d = RUN;
      cause_d = HALT_NONE;
    end else if (busy && stop) begin
      state_d = HALT;
      cause_d = HALT_STOP;
    end else if (commit && (self_jmp || at_limit)) begin
      state_d = HALT;
      cause_d = self_jmp ? HALT_SELF : HALT_LIMIT;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      halt_cause <= HALT_NONE;
      reg_q      <= 1'b0;
      pc_q       <= 1'b0;
      cycle_cnt  <= '0;
      mem[0]     <= 2'b00;
      mem[1]     <= 2'b00;
    end else begin
      state_q    <= state_d;
      halt_cause <= cause_d;
      if (prog_we && !busy) mem[prog_addr] <= prog_data;
      if (enter_run) begin
        reg_q     <= 1'b0;
        pc_q      <= 1'b0;
        cycle_cnt <= '0;
      end else if (commit) begin
        reg_q     <= bus.alu_reg_nxt;
        pc_q      <= bus.alu_pc_nxt;
        cycle_cnt <= cycle_cnt + CYC_W'(1);
      end
    end
  one_bit_trace_slot u_trace (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (enter_run),
    .load        (commit),
    .ready       (bus.trace_ready),
    .new_pc      (pc_q),
    .new_code    (code),
    .new_reg     (bus.alu_reg_nxt),
    .trace_valid (bus.trace_valid),
    .trace_pc    (bus.trace_pc),
    .trace_code  (bus.trace_code),
    .trace_reg   (bus.trace_reg)
  );
endmodule

// File: tb/tb_one_bit_seq.sv
// tb_one_bit_seq: directed self-checking bench for one_bit_seq with a reference one-bit ALU
module tb_one_bit_seq;
  import one_bit_pkg::*;
  logic       clk;
  logic       rst_n;
  logic       prog_we;
  logic       prog_addr;
  logic [1:0] prog_data;
  logic       start;
  logic       step_mode;
  logic       step;
  logic       stop;
  logic       busy;
  logic       halted;
  logic [1:0] halt_cause;
  logic [7:0] cycle_cnt;
  int         n_tests = 0;
  int         n_fail  = 0;
  one_bit_seq_if bus ();
  assign bus.alu_reg_nxt = bus.alu_code[1] == CMD_XOR ? bus.alu_reg ^ bus.alu_code[0] : bus.alu_reg;
  assign bus.alu_pc_nxt  = bus.alu_code[1] == CMD_JMP ? bus.alu_code[0] : ~bus.alu_pc;
  one_bit_seq #(.CYC_W(8), .MAX_CYC(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .start      (start),
    .step_mode  (step_mode),
    .step       (step),
    .stop       (stop),
    .busy       (busy),
    .halted     (halted),
    .halt_cause (halt_cause),
    .cycle_cnt  (cycle_cnt),
    .bus        (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic check_trace(input string tag, input logic v, input logic p, input logic [1:0] c, input logic r);
    check({tag, "_valid"}, 32'(bus.trace_valid), 32'(v));
    check({tag, "_pc"}, 32'(bus.trace_pc), 32'(p));
    check({tag, "_code"}, 32'(bus.trace_code), 32'(c));
    check({tag, "_reg"}, 32'(bus.trace_reg), 32'(r));
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_halted"}, 32'(halted), 0);
    check({tag, "_cause"}, 32'(halt_cause), 0);
    check({tag, "_cnt"}, 32'(cycle_cnt), 0);
    check({tag, "_alu_code"}, 32'(bus.alu_code), 0);
    check({tag, "_alu_reg"}, 32'(bus.alu_reg), 0);
    check({tag, "_alu_pc"}, 32'(bus.alu_pc), 0);
    check_trace({tag, "_tr"}, 0, 0, 2'b00, 0);
  endtask
  initial begin
    logic [4:0] reg_seq;
    reg_seq = 5'b10011;
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = 1'b0; prog_data = 2'b00;
    start = 1'b0; step_mode = 1'b0; step = 1'b0; stop = 1'b0;
    bus.trace_ready = 1'b1;
    #3;
    check_zero("reset");
    cyc();
    rst_n = 1'b1;
    cyc();
    prog_we = 1'b1; prog_addr = 1'b0; prog_data = 2'b01;
    cyc();
    prog_addr = 1'b1; prog_data = 2'b11;
    cyc();
    prog_we = 1'b0;
    check("idle_busy", 32'(busy), 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("sj_busy", 32'(busy), 1);
    check("sj_code0", 32'(bus.alu_code), 32'(2'b01));
    cyc();
    check_trace("sj_tr0", 1, 0, 2'b01, 1);
    check("sj_cnt1", 32'(cycle_cnt), 1);
    cyc();
    check_trace("sj_tr1", 1, 1, 2'b11, 1);
    check("sj_halted", 32'(halted), 1);
    check("sj_cause", 32'(halt_cause), 32'(HALT_SELF));
    check("sj_cnt", 32'(cycle_cnt), 2);
    check("sj_reg", 32'(bus.alu_reg), 1);
    check("sj_pc", 32'(bus.alu_pc), 1);
    cyc();
    check("sj_drain", 32'(bus.trace_valid), 0);
    check("sj_hold_cnt", 32'(cycle_cnt), 2);
    prog_we = 1'b1; prog_addr = 1'b1; prog_data = 2'b10; start = 1'b1;
    cyc();
    prog_we = 1'b0; start = 1'b0;
    check("lim_cnt0", 32'(cycle_cnt), 0);
    check("lim_cause0", 32'(halt_cause), 32'(HALT_NONE));
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("lim_reg%0d", i), 32'(bus.alu_reg), 32'(reg_seq[i]));
      check($sformatf("lim_halt%0d", i), 32'(halted), 32'(i == 4));
    end
    check("lim_cause", 32'(halt_cause), 32'(HALT_LIMIT));
    check("lim_cnt", 32'(cycle_cnt), 5);
    check("lim_pc", 32'(bus.alu_pc), 1);
    cyc();
    check("lim_hold_cnt", 32'(cycle_cnt), 5);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("bp_valid0", 32'(bus.trace_valid), 0);
    cyc();
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check("bp_cnt_stall", 32'(cycle_cnt), 1);
    check("bp_busy", 32'(busy), 1);
    check_trace("bp_tr_hold", 1, 0, 2'b01, 1);
    bus.trace_ready = 1'b1;
    cyc();
    check("bp_cnt2", 32'(cycle_cnt), 2);
    check_trace("bp_tr2", 1, 1, 2'b10, 1);
    for (int i = 0; i < 3; i++) cyc();
    check("bp_halted", 32'(halted), 1);
    check("bp_cause", 32'(halt_cause), 32'(HALT_LIMIT));
    check("bp_cnt", 32'(cycle_cnt), 5);
    step_mode = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step = 1'b1;
      cyc();
      step = 1'b0;
      check($sformatf("st_cnt%0d", k), 32'(cycle_cnt), 32'(k));
      cyc();
      cyc();
      check($sformatf("st_hold%0d", k), 32'(cycle_cnt), 32'(k));
    end
    check("st_reg", 32'(bus.alu_reg), 0);
    check("st_pc", 32'(bus.alu_pc), 1);
    check("st_busy", 32'(busy), 1);
    prog_we = 1'b1; prog_addr = 1'b0; prog_data = 2'b00;
    cyc();
    prog_we = 1'b0;
    stop = 1'b1; step = 1'b1;
    cyc();
    stop = 1'b0; step = 1'b0;
    check("stop_halted", 32'(halted), 1);
    check("stop_cause", 32'(halt_cause), 32'(HALT_STOP));
    check("stop_cnt", 32'(cycle_cnt), 3);
    check("stop_reg", 32'(bus.alu_reg), 0);
    step_mode = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    check("rs_busy", 32'(busy), 1);
    check("rs_cnt", 32'(cycle_cnt), 0);
    check("rs_reg", 32'(bus.alu_reg), 0);
    check("rs_pc", 32'(bus.alu_pc), 0);
    check("rs_cause", 32'(halt_cause), 32'(HALT_NONE));
    check("rs_mem0", 32'(bus.alu_code), 32'(2'b01));
    check("rs_valid", 32'(bus.trace_valid), 0);
    cyc();
    cyc();
    check("mr_cnt", 32'(cycle_cnt), 2);
    check_trace("mr_tr", 1, 1, 2'b10, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mr_reset");
    cyc();
    rst_n = 1'b1;
    cyc();
    check("mr_idle_busy", 32'(busy), 0);
    check("mr_mem1", 32'(bus.alu_code), 32'(2'b00));
    stop = 1'b1; step = 1'b1;
    cyc();
    stop = 1'b0; step = 1'b0;
    check("idle_stop_ignored", 32'(halted), 0);
    check("idle_step_cnt", 32'(cycle_cnt), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
